// File: rtl/wfi_ctrl_if.sv
// Signal bundle between the retire stage / interrupt sources and the WFI controller.
// The master side drives the WFI request and interrupt lines; the controller is the slave.
interface wfi_ctrl_if #(
    parameter int NUM_IRQ   = 8,
    parameter int TIMEOUT_W = 16,
    parameter int ID_W      = $clog2(NUM_IRQ)
);
    logic                 trigger;
    logic [NUM_IRQ-1:0]   irq;
    logic [NUM_IRQ-1:0]   irq_en;
    logic [NUM_IRQ-1:0]   edge_mode;
    logic [NUM_IRQ-1:0]   pending_clr;
    logic [TIMEOUT_W-1:0] timeout;
    logic                 halt;
    logic                 wake;
    logic [ID_W-1:0]      wake_id;
    logic                 wake_timeout;
    logic [NUM_IRQ-1:0]   pending;

    modport master (
        output trigger, irq, irq_en, edge_mode, pending_clr, timeout,
        input  halt, wake, wake_id, wake_timeout, pending
    );

    modport slave (
        input  trigger, irq, irq_en, edge_mode, pending_clr, timeout,
        output halt, wake, wake_id, wake_timeout, pending
    );
endinterface

// File: rtl/wfi_ctrl.sv
// Multi-source wait-for-interrupt controller: stalls the pipeline after a WFI retires
// until an enabled interrupt is pending or the optional cycle timeout expires.
module wfi_ctrl #(
    parameter int NUM_IRQ   = 8,
    parameter int TIMEOUT_W = 16,
    parameter int ID_W      = $clog2(NUM_IRQ)
) (
    input  logic       clk,
    input  logic       reset,
    wfi_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        HALT = 2'b01,
        WAKE = 2'b10
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_IRQ-1:0]   irq_q, irq_d;
    logic [NUM_IRQ-1:0]   pending_q, pending_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0]      wake_id_q, wake_id_d;
    logic                 wake_timeout_q, wake_timeout_d;

    logic [NUM_IRQ-1:0]   masked;
    logic                 wake_req;
    logic [ID_W-1:0]      win_id;
    logic                 timeout_hit;

    // Edge-mode bits latch rising edges (a new edge beats a same-cycle clear); level bits follow irq.
    always_comb begin
        irq_d     = bus.irq;
        pending_d = pending_q;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (bus.edge_mode[i]) begin
                if (bus.irq[i] && !irq_q[i]) begin
                    pending_d[i] = 1'b1;
                end else if (bus.pending_clr[i]) begin
                    pending_d[i] = 1'b0;
                end
            end else begin
                pending_d[i] = bus.irq[i];
            end
        end
    end

    // Lowest-index enabled pending source wins.
    always_comb begin
        masked   = pending_q & bus.irq_en;
        wake_req = |masked;
        win_id   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (masked[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    assign timeout_hit = (bus.timeout != '0) && (cnt_q == bus.timeout - TIMEOUT_W'(1));

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        wake_id_d      = wake_id_q;
        wake_timeout_d = wake_timeout_q;
        case (state_q)
            RUN: begin
                if (bus.trigger) begin
                    if (wake_req) begin
                        state_d        = WAKE;
                        wake_id_d      = win_id;
                        wake_timeout_d = 1'b0;
                    end else begin
                        state_d = HALT;
                        cnt_d   = '0;
                    end
                end
            end
            HALT: begin
                if (wake_req) begin
                    state_d        = WAKE;
                    wake_id_d      = win_id;
                    wake_timeout_d = 1'b0;
                end else if (timeout_hit) begin
                    state_d        = WAKE;
                    wake_id_d      = '0;
                    wake_timeout_d = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
            end
            WAKE: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RUN;
            irq_q          <= '0;
            pending_q      <= '0;
            cnt_q          <= '0;
            wake_id_q      <= '0;
            wake_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            irq_q          <= irq_d;
            pending_q      <= pending_d;
            cnt_q          <= cnt_d;
            wake_id_q      <= wake_id_d;
            wake_timeout_q <= wake_timeout_d;
        end
    end

    assign bus.halt         = (state_q == HALT);
    assign bus.wake         = (state_q == WAKE);
    assign bus.wake_id      = wake_id_q;
    assign bus.wake_timeout = wake_timeout_q;
    assign bus.pending      = pending_q;

endmodule
